// File: rtl/sipo_demux_pkg.sv
// sipo_pkg: shared FSM state type and default frame width for sipo_demux
package sipo_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/sipo_demux_demux1n.sv
// demux1n: 1-to-N one-hot decoder of a slot index, gated by an enable
module demux1n #(
    parameter int N  = 8,
    parameter int CW = $clog2(N)
) (
    input  logic [CW-1:0] sel,
    input  logic          en,
    output logic [N-1:0]  onehot
);
    for (genvar i = 0; i < N; i++) begin : g_dec
        assign onehot[i] = en && (sel == CW'(i));
    end
endmodule

// File: rtl/sipo_demux.sv
// sipo_demux: LSB-first serial-to-parallel frame receiver with optional even parity
module sipo_demux
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             parity_err,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shadow, shadow_nxt, we;
    logic             last;
    demux1n #(.N(WIDTH), .CW(CW)) u_dec (
        .sel    (cnt),
        .en     (din_valid && state == DATA && !sof),
        .onehot (we)
    );
    assign shadow_nxt = (shadow & ~we) | ({WIDTH{din}} & we);
    assign last       = cnt == CW'(WIDTH - 1);
    assign busy       = state != IDLE;
    // Frame FSM: sof restarts from any state, data slots fill in order, parity bit commits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shadow     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (din_valid && sof) begin
                shadow <= WIDTH'(din);
                cnt    <= CW'(1);
                state  <= DATA;
            end else if (din_valid && state == DATA) begin
                shadow <= shadow_nxt;
                cnt    <= last ? '0 : cnt + CW'(1);
                if (last && PARITY_EN) begin
                    state <= PARITY;
                end else if (last) begin
                    state      <= IDLE;
                    dout       <= shadow_nxt;
                    dout_valid <= 1'b1;
                end
            end else if (din_valid && state == PARITY) begin
                state      <= IDLE;
                dout       <= shadow;
                parity_err <= din ^ (^shadow);
                dout_valid <= 1'b1;
            end
        end
    end
endmodule

// File: doc/sipo_demux.md
SIPO_DEMUX -- requirements
Module: sipo_demux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of data bits per frame (valid range 2..32).
REQ-002 The block SHALL have parameter PARITY_EN, default 1, which appends one even-parity bit to each frame when set.
REQ-003 Port clk SHALL be input, width 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be input, width 1, the asynchronous active-high reset.
REQ-005 Port din SHALL be input, width 1, the serial data bit.
REQ-006 Port din_valid SHALL be input, width 1, qualifying din in the current cycle.
REQ-007 Port sof SHALL be input, width 1, start-of-frame, meaningful only when din_valid=1.
REQ-008 Port dout SHALL be output, width WIDTH, the last committed parallel word.
REQ-009 Port dout_valid SHALL be output, width 1, a one-cycle pulse marking a new dout.
REQ-010 Port parity_err SHALL be output, width 1, the parity mismatch flag for the current dout.
REQ-011 Port busy SHALL be output, width 1, high while a frame is partially received.

Function
REQ-012 The block SHALL demultiplex serial bits LSB-first into a WIDTH-bit shadow register, one slot per accepted bit, with slot index taken from a bit counter.
REQ-013 The FSM SHALL have states IDLE, DATA and PARITY, with busy = (state != IDLE).
REQ-014 In IDLE, din_valid&sof SHALL clear the shadow register, write din to slot 0, set the counter to 1 and enter DATA; din_valid without sof SHALL be ignored.
REQ-015 In DATA, each din_valid SHALL write din to slot counter and increment the counter.
REQ-016 Writing slot WIDTH-1 SHALL enter PARITY if PARITY_EN=1; otherwise it SHALL commit the frame and return to IDLE.
REQ-017 In PARITY, din_valid SHALL commit the frame with parity_err = din XOR (XOR-reduce of shadow), then return to IDLE.
REQ-018 A commit SHALL load dout from the shadow register and pulse dout_valid for exactly one cycle, in the cycle after the final bit is sampled.
REQ-019 dout and parity_err SHALL hold their values until the next commit; with PARITY_EN=0, parity_err SHALL stay 0.
REQ-020 When din_valid=0, state, counter and shadow SHALL hold indefinitely, with no timeout.
REQ-021 din_valid&sof in DATA or PARITY SHALL abort the partial frame without committing and restart it as in REQ-014; the restart takes precedence over advancing the counter.
REQ-022 A new sof SHALL be accepted in the cycle in which dout_valid is high, so back-to-back frames incur no dead cycle.
REQ-023 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-024 Asserting rst SHALL immediately force state IDLE and set the counter, shadow, dout, dout_valid, parity_err and busy to 0, independent of clk.
REQ-025 After rst deasserts, the first accepted bit SHALL be the first din_valid&sof on a clk edge.

Structure
REQ-026 Package sipo_pkg SHALL hold the FSM state enum and the default WIDTH constant.
REQ-027 The write-enable decode SHALL be a combinational sub-module demux1n (1-to-WIDTH one-hot decoder of counter, gated by din_valid).

Verification
REQ-028 Scenario 1 (WIDTH=8, PARITY_EN=1): sof with bits 1,0,1,1,0,0,1,0 followed by parity 0 -> dout=0x4D, dout_valid for 1 cycle after the parity bit, parity_err=0.
REQ-029 Scenario 2: same frame with parity bit 1 -> dout=0x4D, parity_err=1.
REQ-030 Scenario 3: din_valid low for 5 cycles after bit 3 of the frame in Scenario 1 -> busy stays 1 throughout, result identical to Scenario 1.
REQ-031 Scenario 4: sof reasserted on bit 5, then eight 1-bits and parity 0 -> exactly one dout_valid, dout=0xFF, parity_err=0.
REQ-032 Scenario 5: rst pulsed after 4 bits -> dout=0, busy=0 and dout_valid=0 without waiting for a clk edge; a following frame 0x01 with parity 1 -> dout=0x01, parity_err=0.
REQ-033 Scenario 6: two frames (0xA5 then 0x3C, both parity 0) with the second sof in the dout_valid cycle -> two pulses 9 cycles apart, both parity_err=0.
